avg_bram_reader: RTL

- Downstream stage of the trace averager. When the averager signals its run is finished, this block reads the accumulated trace out of the shared BRAM, one word per sample.
- Each 32-bit signed sum is scaled by an arithmetic right shift, dividing by 2^shift (use when naverages is a power of two).
- Samples are streamed out as an AXI4-Stream packet of nsamples beats for the DMA/FIFO path to the PS.
- The block owns the BRAM read port only. The averager keeps the write port.

---
 rtl/avg_pkg.sv | 13 +
 rtl/avg_out_fifo.sv | 57 +++++
 rtl/avg_bram_reader.sv | 115 +++++++++++
 3 files changed

// File: rtl/avg_pkg.sv
// Shared types and constants for the trace-averager readout path.
// The FIFO entry pairs a scaled sample with its end-of-packet flag.
package avg_pkg;
  localparam int DATA_WIDTH      = 32;
  localparam int BRAM_RD_LATENCY = 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/avg_out_fifo.sv
// Two-entry synchronous FIFO; the head entry lives in its own register so
// the stream outputs come straight from flops.
module avg_out_fifo
  import avg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_push,
  input  fifo_entry_t i_din,
  input  logic        i_pop,
  output fifo_entry_t o_dout,
  output logic        o_empty,
  output logic [1:0]  o_count
);
  fifo_entry_t r_head, r_tail;
  logic [1:0]  r_count;
  logic        w_pop;

  assign w_pop   = i_pop && (r_count != 2'd0);
  assign o_dout  = r_head;
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      unique case ({i_push, w_pop})
        2'b10: begin
          // a push into a full FIFO is dropped; the reader's credit check prevents it
          if (r_count == 2'd0) begin
            r_head  <= i_din;
            r_count <= 2'd1;
          end else if (r_count == 2'd1) begin
            r_tail  <= i_din;
            r_count <= 2'd2;
          end
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= i_din;
          end else begin
            r_head <= r_tail;
            r_tail <= i_din;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/avg_bram_reader.sv
// Reads an accumulated trace out of BRAM after the averager finishes,
// scales each sum by an arithmetic right shift and streams it as one AXIS packet.
module avg_bram_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           nsamples,
  input  logic [4:0]            shift,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  input  logic [DATA_WIDTH-1:0] bram_rddata,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done
);
  import avg_pkg::*;

  state_t      r_state;
  logic        r_start_d, r_busy, r_done, r_inflight;
  logic [15:0] r_n, r_rd_idx, r_out_idx;
  logic [4:0]  r_sh;

  logic        w_edge, w_pop, w_issue, w_empty;
  logic [1:0]  w_count;
  logic [2:0]  w_occ;
  fifo_entry_t w_din, w_head;

  assign w_edge = start & ~r_start_d;
  assign w_pop  = m_axis_tvalid & m_axis_tready;

  // Occupancy seen by the next read: buffered + in flight, minus what leaves this cycle.
  assign w_occ   = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_state == READ) && (r_rd_idx < r_n) && (w_occ < 3'(FIFO_DEPTH));

  assign bram_en   = w_issue;
  assign bram_addr = w_issue ? ADDR_WIDTH'({r_rd_idx, 2'b00}) : '0;

  always_comb begin
    w_din      = '0;
    w_din.data = $signed(bram_rddata) >>> r_sh;
    w_din.last = (r_out_idx == 16'(r_n - 16'd1));
  end

  avg_out_fifo u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_inflight),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign m_axis_tdata  = w_head.data;
  assign m_axis_tlast  = w_head.last;
  assign m_axis_tvalid = !w_empty;
  assign busy          = r_busy;
  assign done          = r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_start_d  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_inflight <= 1'b0;
      r_n        <= '0;
      r_sh       <= '0;
      r_rd_idx   <= '0;
      r_out_idx  <= '0;
    end else begin
      r_start_d  <= start;
      r_inflight <= w_issue;
      r_done     <= 1'b0;
      if (w_issue)    r_rd_idx  <= r_rd_idx + 16'd1;
      if (r_inflight) r_out_idx <= r_out_idx + 16'd1;
      unique case (r_state)
        IDLE: begin
          if (w_edge) begin
            if (nsamples != 16'd0) begin
              r_n       <= nsamples;
              r_sh      <= shift;
              r_rd_idx  <= '0;
              r_out_idx <= '0;
              r_busy    <= 1'b1;
              r_state   <= READ;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        READ: begin
          if (r_rd_idx == r_n) r_state <= DRAIN;
        end
        DRAIN: begin
          // all reads issued, nothing buffered or in flight: last beat has left
          if (w_empty && !r_inflight) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
